lsu_mc: RTL and testbench
=========================

LSU_MC -- requirements
Module: lsu_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, memory/GPR data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH, byte address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, maximum cycles spent in WAIT before a bus error; legal range 1..65535.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_lsu_valid / o_lsu_ready  in/out  1/1  upstream request handshake.
REQ-008 i_lsu_rd_en, i_lsu_wr_en  in  1 each  load or store; both low = pass-through, no bus access.
REQ-009 i_lsu_byt  in  `ARGS_WIDTH  size/sign code, `RAM_BYT_* encoding.
REQ-010 i_lsu_addr  in  ADDR_WIDTH  byte address; i_lsu_wr_data  in  DATA_WIDTH  store data, LSB-aligned.
REQ-011 o_ram_req_valid / i_ram_req_ready  out/in  1/1  bus request handshake.
REQ-012 o_ram_req_wr  out 1; o_ram_req_addr  out ADDR_WIDTH, word-aligned; o_ram_req_data  out DATA_WIDTH; o_ram_req_mask  out DATA_WIDTH/8.
REQ-013 i_ram_rsp_valid / o_ram_rsp_ready  in/out  1/1; i_ram_rsp_data  in  DATA_WIDTH.
REQ-014 o_lsu_valid / i_wbu_ready  out/in  1/1  result handshake; o_lsu_gpr_wr_data  out DATA_WIDTH; o_lsu_err  out 1  access fault.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DONE; o_lsu_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on i_lsu_valid, register all request fields; go to REQ if rd_en or wr_en, else DONE with o_lsu_gpr_wr_data = captured i_lsu_addr zero-extended.
REQ-017 REQ: o_ram_req_valid = 1 with fields stable until i_ram_req_ready; on handshake go to WAIT.
REQ-018 o_ram_req_addr SHALL be address with low log2(DATA_WIDTH/8) bits cleared.
REQ-019 Store: data SHALL be shifted left by 8 x (address offset) bits; mask = size mask (1/2/4/8 bytes, from `RAM_BYT_*` size ignoring sign) shifted left by offset.
REQ-020 Load: o_ram_req_mask SHALL equal the same shifted size mask; o_ram_req_data SHALL be 0.
REQ-021 WAIT: o_ram_rsp_ready = 1; on i_ram_rsp_valid, loads SHALL shift response right by 8 x offset, then sign- or zero-extend per i_lsu_byt; stores produce result 0; go to DONE.
REQ-022 WAIT SHALL count cycles; reaching TIMEOUT_CYC without response SHALL go to DONE with o_lsu_err = 1 and result 0; response arriving on the timeout cycle SHALL win (no error).
REQ-023 DONE: o_lsu_valid = 1, result and o_lsu_err held stable until i_wbu_ready; then IDLE.
REQ-024 End-to-end latency with zero-wait bus and ready writeback SHALL be 3 cycles from request accept to o_lsu_valid.
REQ-025 8-byte codes with DATA_WIDTH = 32 SHALL be treated as 4-byte.
REQ-026 i_lsu_rd_en and i_lsu_wr_en both high SHALL execute as store.
REQ-027 Inputs other than handshakes SHALL be ignored outside the IDLE accept cycle.

Reset
REQ-028 i_rst SHALL force IDLE, clear timeout counter and all registered fields, and drive every output to 0 except o_lsu_ready = 1 on the first post-reset cycle.
REQ-029 Reset mid-transaction SHALL abandon it; a later stray i_ram_rsp_valid in IDLE SHALL be ignored.

Configuration
REQ-030 Macro LSU_ALIGN_CHK_EN: when defined, an access whose address is not a multiple of its size SHALL skip REQ/WAIT, go directly to DONE with o_lsu_err = 1, result 0, no bus request.
REQ-031 When LSU_ALIGN_CHK_EN is undefined, misaligned accesses SHALL be issued as in REQ-019/021, with bytes beyond the word boundary dropped (mask truncated to DATA_WIDTH/8 bits).

Verification
REQ-032 DATA_WIDTH 32, load `RAM_BYT_1_S` addr 0x1003, rsp 0x80FFFFFF -> mask 0x8, result 0xFFFFFF80, o_lsu_err 0.
REQ-033 Store `RAM_BYT_2_U` addr 0x2002 data 0x1234, req_ready low 3 cycles -> fields stable, addr 0x2000, data 0x12340000, mask 0xC.
REQ-034 TIMEOUT_CYC 4, load with no response -> o_lsu_valid with o_lsu_err 1 after 4 WAIT cycles; result 0.
REQ-035 i_wbu_ready low 5 cycles in DONE -> o_lsu_valid and result held; o_lsu_ready 0 throughout.
REQ-036 LSU_ALIGN_CHK_EN defined, `RAM_BYT_4_S` load addr 0x1001 -> no o_ram_req_valid, o_lsu_err 1 next cycle.
REQ-037 i_rst asserted in WAIT, then rsp valid -> state IDLE, o_lsu_valid stays 0.

Source files
------------

// File: rtl/lsu_mc.sv
// ---------------------------------------------------------------------------
// lsu_mc -- multi-cycle load/store unit
//
// Accepts one load, store or pass-through request at a time, issues a single
// word-aligned bus request, waits (bounded) for the response, aligns and
// extends load data, then presents the result to writeback.
//
// Optional feature macro: LSU_ALIGN_CHK_EN
//   defined   : accesses whose address is not a multiple of their size fault
//               immediately (no bus request, o_lsu_err = 1, result 0).
//   undefined : misaligned accesses are issued; bytes past the word boundary
//               are dropped.
//
// Ports
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_lsu_valid / o_lsu_ready         upstream request handshake
//   i_lsu_rd_en, i_lsu_wr_en          load / store (both low = pass-through)
//   i_lsu_byt                         size/sign code (`RAM_BYT_*)
//   i_lsu_addr, i_lsu_wr_data         byte address, LSB-aligned store data
//   o_ram_req_valid / i_ram_req_ready bus request handshake
//   o_ram_req_wr/addr/data/mask       bus request fields
//   i_ram_rsp_valid / o_ram_rsp_ready bus response handshake
//   i_ram_rsp_data                    bus response data
//   o_lsu_valid / i_wbu_ready         result handshake
//   o_lsu_gpr_wr_data, o_lsu_err      result data, access fault
// ---------------------------------------------------------------------------

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
// Code layout: bits [1:0] = log2(bytes), bit 2 = sign-extend loads.
`ifndef RAM_BYT_1_U
`define RAM_BYT_1_U 3'b000
`endif
`ifndef RAM_BYT_2_U
`define RAM_BYT_2_U 3'b001
`endif
`ifndef RAM_BYT_4_U
`define RAM_BYT_4_U 3'b010
`endif
`ifndef RAM_BYT_8_U
`define RAM_BYT_8_U 3'b011
`endif
`ifndef RAM_BYT_1_S
`define RAM_BYT_1_S 3'b100
`endif
`ifndef RAM_BYT_2_S
`define RAM_BYT_2_S 3'b101
`endif
`ifndef RAM_BYT_4_S
`define RAM_BYT_4_S 3'b110
`endif
`ifndef RAM_BYT_8_S
`define RAM_BYT_8_S 3'b111
`endif

module lsu_mc #(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_lsu_valid,
    output logic                    o_lsu_ready,
    input  logic                    i_lsu_rd_en,
    input  logic                    i_lsu_wr_en,
    input  logic [`ARGS_WIDTH-1:0]  i_lsu_byt,
    input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
    input  logic [DATA_WIDTH-1:0]   i_lsu_wr_data,
    output logic                    o_ram_req_valid,
    input  logic                    i_ram_req_ready,
    output logic                    o_ram_req_wr,
    output logic [ADDR_WIDTH-1:0]   o_ram_req_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_req_data,
    output logic [DATA_WIDTH/8-1:0] o_ram_req_mask,
    input  logic                    i_ram_rsp_valid,
    output logic                    o_ram_rsp_ready,
    input  logic [DATA_WIDTH-1:0]   i_ram_rsp_data,
    output logic                    o_lsu_valid,
    input  logic                    i_wbu_ready,
    output logic [DATA_WIDTH-1:0]   o_lsu_gpr_wr_data,
    output logic                    o_lsu_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFW   = $clog2(NBYTES);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic                     isStore_q, isStore_d;
    logic [`ARGS_WIDTH-1:0]   byt_q, byt_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wrData_q, wrData_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic                     err_q, err_d;

    // 8-byte codes collapse to 4-byte on a 32-bit datapath.
    function automatic logic [1:0] effSize(input logic [`ARGS_WIDTH-1:0] byt);
        if (DATA_WIDTH == 32 && byt[1:0] == 2'd3) return 2'd2;
        return byt[1:0];
    endfunction

    logic [1:0]            sz;
    logic [OFFW+2:0]       shiftBits;
    logic [7:0]            sizeMask;
    logic [NBYTES-1:0]     reqMask;
    logic [DATA_WIDTH-1:0] storeData;
    logic [DATA_WIDTH-1:0] rspShifted;
    logic [DATA_WIDTH-1:0] keepMask;
    logic                  signBit;
    logic [DATA_WIDTH-1:0] loadExt;

    // Datapath built from the captured request: byte-lane mask and store
    // data are moved up to the addressed lane, load data is brought down to
    // bit 0 and then extended past the access size.
    always_comb begin
        sz        = effSize(byt_q);
        shiftBits = {addr_q[OFFW-1:0], 3'b000};
        case (sz)
            2'd0:    sizeMask = 8'h01;
            2'd1:    sizeMask = 8'h03;
            2'd2:    sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase
        // Lanes shifted past the top of the word fall off here.
        reqMask    = NBYTES'(sizeMask) << addr_q[OFFW-1:0];
        storeData  = wrData_q << shiftBits;
        rspShifted = i_ram_rsp_data >> shiftBits;
        case (sz)
            2'd0: begin
                keepMask = DATA_WIDTH'(8'hFF);
                signBit  = rspShifted[7];
            end
            2'd1: begin
                keepMask = DATA_WIDTH'(16'hFFFF);
                signBit  = rspShifted[15];
            end
            2'd2: begin
                keepMask = DATA_WIDTH'(32'hFFFF_FFFF);
                signBit  = rspShifted[31];
            end
            default: begin
                keepMask = {DATA_WIDTH{1'b1}};
                signBit  = rspShifted[DATA_WIDTH-1];
            end
        endcase
        loadExt = (rspShifted & keepMask) |
                  ((byt_q[2] && signBit) ? ~keepMask : '0);
    end

`ifdef LSU_ALIGN_CHK_EN
    logic [1:0] inSz;
    logic [2:0] alignMask;
    logic       misaligned;

    // Misalignment is judged on the incoming request so a fault can be
    // reported without ever touching the bus.
    always_comb begin
        inSz = effSize(i_lsu_byt);
        case (inSz)
            2'd0:    alignMask = 3'b000;
            2'd1:    alignMask = 3'b001;
            2'd2:    alignMask = 3'b011;
            default: alignMask = 3'b111;
        endcase
        misaligned = |(i_lsu_addr[2:0] & alignMask);
    end
`endif

    // Next-state logic: request capture in IDLE, bus handshake in REQ,
    // bounded response wait in WAIT, writeback hold in DONE.
    always_comb begin
        state_d   = state_q;
        isStore_d = isStore_q;
        byt_d     = byt_q;
        addr_d    = addr_q;
        wrData_d  = wrData_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (i_lsu_valid) begin
                    // Store wins when both enables are set.
                    isStore_d = i_lsu_wr_en;
                    byt_d     = i_lsu_byt;
                    addr_d    = i_lsu_addr;
                    wrData_d  = i_lsu_wr_data;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    result_d  = '0;
                    if (i_lsu_rd_en || i_lsu_wr_en) begin
`ifdef LSU_ALIGN_CHK_EN
                        if (misaligned) begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
`else
                        state_d = REQ;
`endif
                    end else begin
                        state_d  = DONE;
                        result_d = DATA_WIDTH'(i_lsu_addr);
                    end
                end
            end
            REQ: begin
                if (i_ram_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // A response on the final counted cycle still wins.
                if (i_ram_rsp_valid) begin
                    state_d  = DONE;
                    result_d = isStore_q ? '0 : loadExt;
                    err_d    = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = DONE;
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                if (i_wbu_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured fields; reset clears everything back to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            isStore_q <= 1'b0;
            byt_q     <= '0;
            addr_q    <= '0;
            wrData_q  <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            isStore_q <= isStore_d;
            byt_q     <= byt_d;
            addr_q    <= addr_d;
            wrData_q  <= wrData_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    // Outputs are qualified by state so idle buses read as zero.
    always_comb begin
        o_lsu_ready       = (state_q == IDLE);
        o_ram_req_valid   = (state_q == REQ);
        o_ram_req_wr      = (state_q == REQ) && isStore_q;
        o_ram_req_addr    = '0;
        o_ram_req_data    = '0;
        o_ram_req_mask    = '0;
        if (state_q == REQ) begin
            o_ram_req_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
            o_ram_req_mask = reqMask;
            if (isStore_q) o_ram_req_data = storeData;
        end
        o_ram_rsp_ready   = (state_q == WAIT);
        o_lsu_valid       = (state_q == DONE);
        o_lsu_gpr_wr_data = (state_q == DONE) ? result_q : '0;
        o_lsu_err         = (state_q == DONE) && err_q;
    end

endmodule

// File: tb/tb_lsu_mc.sv
// ---------------------------------------------------------------------------
// tb_lsu_mc -- directed self-checking bench for lsu_mc (DATA_WIDTH 32,
// ADDR_WIDTH 32, TIMEOUT_CYC 4). Inputs change 1 ns after the rising edge
// and outputs are sampled at that same point.
// ---------------------------------------------------------------------------

`ifndef RAM_BYT_1_U
`define RAM_BYT_1_U 3'b000
`endif
`ifndef RAM_BYT_2_U
`define RAM_BYT_2_U 3'b001
`endif
`ifndef RAM_BYT_4_U
`define RAM_BYT_4_U 3'b010
`endif
`ifndef RAM_BYT_4_S
`define RAM_BYT_4_S 3'b110
`endif
`ifndef RAM_BYT_8_S
`define RAM_BYT_8_S 3'b111
`endif
`ifndef RAM_BYT_1_S
`define RAM_BYT_1_S 3'b100
`endif

module tb_lsu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsuValid, lsuReady, rdEn, wrEn;
    logic [2:0]  byt;
    logic [31:0] addr, wrData;
    logic        reqValid, reqReady, reqWr;
    logic [31:0] reqAddr, reqData;
    logic [3:0]  reqMask;
    logic        rspValid, rspReady;
    logic [31:0] rspData;
    logic        outValid, wbuReady;
    logic [31:0] result;
    logic        err;

    int testsRun    = 0;
    int testsFailed = 0;

    lsu_mc #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYC(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_lsu_valid(lsuValid), .o_lsu_ready(lsuReady),
        .i_lsu_rd_en(rdEn), .i_lsu_wr_en(wrEn), .i_lsu_byt(byt),
        .i_lsu_addr(addr), .i_lsu_wr_data(wrData),
        .o_ram_req_valid(reqValid), .i_ram_req_ready(reqReady),
        .o_ram_req_wr(reqWr), .o_ram_req_addr(reqAddr),
        .o_ram_req_data(reqData), .o_ram_req_mask(reqMask),
        .i_ram_rsp_valid(rspValid), .o_ram_rsp_ready(rspReady),
        .i_ram_rsp_data(rspData),
        .o_lsu_valid(outValid), .i_wbu_ready(wbuReady),
        .o_lsu_gpr_wr_data(result), .o_lsu_err(err)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
        lsuValid = 1'b1; rdEn = rd; wrEn = wr; byt = b; addr = a; wrData = d;
        tick();
        lsuValid = 1'b0; rdEn = 1'b0; wrEn = 1'b0; byt = 3'b000;
        addr = 32'hFFFF_FFFF; wrData = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset;
        rst = 1'b1; lsuValid = 0; rdEn = 0; wrEn = 0; byt = 0; addr = 0; wrData = 0;
        reqReady = 0; rspValid = 0; rspData = 0; wbuReady = 0;
        tick(); tick();
        rst = 1'b0;
        testsRun++;
        if ({lsuReady, reqValid, reqWr, reqAddr, reqData, reqMask, rspReady, outValid, result, err}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got ready=%b reqv=%b addr=%h data=%h mask=%h rspr=%b valid=%b res=%h err=%b, required ready=1 all others 0",
                     lsuReady, reqValid, reqAddr, reqData, reqMask, rspReady, outValid, result, err);
        end
    endtask

    // Signed byte load at offset 3; also checks the 3-cycle accept-to-valid latency.
    task automatic test_load_signed;
        reqReady = 1'b1; wbuReady = 1'b0;
        applyStimulus(1'b1, 1'b0, `RAM_BYT_1_S, 32'h0000_1003, 32'h0);
        testsRun++;
        if ({reqValid, reqWr, reqAddr, reqData, reqMask} !== {1'b1, 1'b0, 32'h1000, 32'h0, 4'h8}) begin
            testsFailed++;
            $display("[TB] FAIL load_req: got v=%b wr=%b addr=%h data=%h mask=%h, required 1 0 00001000 00000000 8",
                     reqValid, reqWr, reqAddr, reqData, reqMask);
        end
        tick();
        testsRun++;
        if ({rspReady, reqValid} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL load_wait: got rspReady=%b reqValid=%b, required 1 0", rspReady, reqValid);
        end
        rspValid = 1'b1; rspData = 32'h80FF_FFFF;
        tick();
        rspValid = 1'b0; rspData = 32'h0;
        testsRun++;
        if ({outValid, result, err} !== {1'b1, 32'hFFFF_FF80, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL load_result: got valid=%b res=%h err=%b, required 1 ffffff80 0",
                     outValid, result, err);
        end
        wbuReady = 1'b1;
        tick();
        testsRun++;
        if ({lsuReady, outValid} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL load_release: got ready=%b valid=%b, required 1 0", lsuReady, outValid);
        end
    endtask

    // Halfword store at offset 2 with the bus stalling for 3 cycles.
    task automatic test_store_stall;
        reqReady = 1'b0; wbuReady = 1'b0;
        applyStimulus(1'b0, 1'b1, `RAM_BYT_2_U, 32'h0000_2002, 32'h0000_1234);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) reqReady = 1'b1;
            testsRun++;
            if ({reqValid, reqWr, reqAddr, reqData, reqMask} !== {1'b1, 1'b1, 32'h2000, 32'h1234_0000, 4'hC}) begin
                testsFailed++;
                $display("[TB] FAIL store_req_cycle%0d: got v=%b wr=%b addr=%h data=%h mask=%h, required 1 1 00002000 12340000 c",
                         i, reqValid, reqWr, reqAddr, reqData, reqMask);
            end
            tick();
        end
        reqReady = 1'b0;
        rspValid = 1'b1; rspData = 32'hDEAD_BEEF;
        tick();
        rspValid = 1'b0;
        testsRun++;
        if ({outValid, result, err} !== {1'b1, 32'h0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL store_result: got valid=%b res=%h err=%b, required 1 00000000 0",
                     outValid, result, err);
        end
        wbuReady = 1'b1;
        tick();
    endtask

    // No response: WAIT lasts exactly 4 cycles then faults.
    task automatic test_timeout;
        reqReady = 1'b1; wbuReady = 1'b0;
        applyStimulus(1'b1, 1'b0, `RAM_BYT_4_U, 32'h0000_3000, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if ({rspReady, outValid} !== 2'b10) begin
                testsFailed++;
                $display("[TB] FAIL timeout_wait%0d: got rspReady=%b valid=%b, required 1 0", i, rspReady, outValid);
            end
            tick();
        end
        testsRun++;
        if ({outValid, result, err} !== {1'b1, 32'h0, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL timeout_err: got valid=%b res=%h err=%b, required 1 00000000 1",
                     outValid, result, err);
        end
        wbuReady = 1'b1;
        tick();
    endtask

    // Response on the last allowed WAIT cycle beats the timeout.
    task automatic test_timeout_race;
        reqReady = 1'b1; wbuReady = 1'b0;
        applyStimulus(1'b1, 1'b0, `RAM_BYT_4_U, 32'h0000_3000, 32'h0);
        tick();
        tick(); tick(); tick();
        rspValid = 1'b1; rspData = 32'h1122_3344;
        tick();
        rspValid = 1'b0;
        testsRun++;
        if ({outValid, result, err} !== {1'b1, 32'h1122_3344, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL timeout_race: got valid=%b res=%h err=%b, required 1 11223344 0",
                     outValid, result, err);
        end
        wbuReady = 1'b1;
        tick();
    endtask

    // Pass-through held in DONE while writeback stalls for 5 cycles.
    task automatic test_wb_stall;
        wbuReady = 1'b0;
        applyStimulus(1'b0, 1'b0, `RAM_BYT_1_U, 32'h0000_ABCD, 32'h0);
        for (int i = 0; i < 5; i++) begin
            testsRun++;
            if ({outValid, result, err, lsuReady, reqValid} !== {1'b1, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0}) begin
                testsFailed++;
                $display("[TB] FAIL wb_stall%0d: got valid=%b res=%h err=%b ready=%b reqv=%b, required 1 0000abcd 0 0 0",
                         i, outValid, result, err, lsuReady, reqValid);
            end
            tick();
        end
        wbuReady = 1'b1;
        tick();
        testsRun++;
        if ({lsuReady, outValid} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL wb_release: got ready=%b valid=%b, required 1 0", lsuReady, outValid);
        end
    endtask

    // Both enables set executes as a store; 8-byte code clamps to 4 bytes.
    task automatic test_both_en_and_clamp;
        reqReady = 1'b0; wbuReady = 1'b1;
        applyStimulus(1'b1, 1'b1, `RAM_BYT_4_U, 32'h0000_4000, 32'hCAFE_BABE);
        testsRun++;
        if ({reqWr, reqData, reqMask} !== {1'b1, 32'hCAFE_BABE, 4'hF}) begin
            testsFailed++;
            $display("[TB] FAIL both_en: got wr=%b data=%h mask=%h, required 1 cafebabe f", reqWr, reqData, reqMask);
        end
        reqReady = 1'b1; tick();
        rspValid = 1'b1; rspData = 32'h0000_0055; tick();
        rspValid = 1'b0; tick();
        applyStimulus(1'b1, 1'b0, `RAM_BYT_8_S, 32'h0000_5004, 32'h0);
        testsRun++;
        if ({reqAddr, reqMask} !== {32'h5004, 4'hF}) begin
            testsFailed++;
            $display("[TB] FAIL clamp_req: got addr=%h mask=%h, required 00005004 f", reqAddr, reqMask);
        end
        tick();
        rspValid = 1'b1; rspData = 32'h8765_4321; tick();
        rspValid = 1'b0;
        testsRun++;
        if ({result, err} !== {32'h8765_4321, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL clamp_result: got res=%h err=%b, required 87654321 0", result, err);
        end
        tick();
    endtask

    task automatic test_misaligned;
        reqReady = 1'b0; wbuReady = 1'b0;
`ifdef LSU_ALIGN_CHK_EN
        applyStimulus(1'b1, 1'b0, `RAM_BYT_4_S, 32'h0000_1001, 32'h0);
        testsRun++;
        if ({reqValid, outValid, err, result} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            testsFailed++;
            $display("[TB] FAIL align_fault: got reqv=%b valid=%b err=%b res=%h, required 0 1 1 00000000",
                     reqValid, outValid, err, result);
        end
        wbuReady = 1'b1;
        tick();
`else
        applyStimulus(1'b0, 1'b1, `RAM_BYT_4_U, 32'h0000_1001, 32'hAABB_CCDD);
        testsRun++;
        if ({reqValid, reqAddr, reqData, reqMask} !== {1'b1, 32'h1000, 32'hBBCC_DD00, 4'hE}) begin
            testsFailed++;
            $display("[TB] FAIL misaligned_trunc: got v=%b addr=%h data=%h mask=%h, required 1 00001000 bbccdd00 e",
                     reqValid, reqAddr, reqData, reqMask);
        end
        reqReady = 1'b1; tick();
        rspValid = 1'b1; tick();
        rspValid = 1'b0; wbuReady = 1'b1; tick();
`endif
    endtask

    // Reset in WAIT abandons the access; a stray response is then ignored.
    task automatic test_reset_mid;
        reqReady = 1'b1; wbuReady = 1'b1;
        applyStimulus(1'b1, 1'b0, `RAM_BYT_4_U, 32'h0000_6000, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        testsRun++;
        if ({lsuReady, rspReady, outValid} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_state: got ready=%b rspReady=%b valid=%b, required 1 0 0",
                     lsuReady, rspReady, outValid);
        end
        rspValid = 1'b1; rspData = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            tick();
            testsRun++;
            if ({lsuReady, outValid, result} !== {1'b1, 1'b0, 32'h0}) begin
                testsFailed++;
                $display("[TB] FAIL stray_rsp%0d: got ready=%b valid=%b res=%h, required 1 0 00000000",
                         i, lsuReady, outValid, result);
            end
        end
        rspValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_signed();
        test_store_stall();
        test_timeout();
        test_timeout_race();
        test_wb_stall();
        test_both_en_and_clamp();
        test_misaligned();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
